// File: rtl/mem_responder.sv
// mem_responder
//   Memory-side responder for the CPU's 8-bit memory bus. Holds a 2^ADDR_W x DATA_W RAM,
//   serves CPU writes in one clock and CPU reads with a fixed READ_LAT latency. A programmer
//   port fills the RAM sequentially before the CPU is released.
//
// Parameters
//   ADDR_W    address width, depth = 2^ADDR_W
//   DATA_W    data / bus width
//   READ_LAT  clocks from a read request on the bus to Data driven (1..3)
//
// Ports
//   clk, master_reset_n   clock (rising edge) and asynchronous active-low reset
//   CS, WE, OE, Address   CPU bus controls and address (active high)
//   Data                  bidirectional bus, driven only while a read is presented
//   prog_en               programming mode; CPU bus ignored while high
//   prog_valid/prog_data  programming byte stream
//   prog_ready            byte accepted this cycle when prog_valid is high
//   prog_addr             address the next programming byte will land at
//   prog_done             whole RAM written; sticky until prog_en falls
//   rd_valid              Data currently carries valid read data
//   busy                  read in flight (waiting out the latency)

module mem_responder #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              master_reset_n,
  input  logic              CS,
  input  logic              WE,
  input  logic              OE,
  input  logic [ADDR_W-1:0] Address,
  inout  wire  [DATA_W-1:0] Data,
  input  logic              prog_en,
  input  logic              prog_valid,
  input  logic [DATA_W-1:0] prog_data,
  output logic              prog_ready,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              prog_done,
  output logic              rd_valid,
  output logic              busy
);

  localparam int unsigned     Depth    = 2 ** ADDR_W;
  localparam logic [1:0]      LatInit  = 2'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] AddrLast = '1;

  typedef enum logic [1:0] {
    StIdle,
    StRdWait,
    StRdDrive,
    StProg
  } state_e;

  state_e              state_q;
  logic [1:0]          cnt_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [ADDR_W-1:0]   prog_addr_q;
  logic                prog_done_q;

  logic [DATA_W-1:0]   mem [Depth];

  logic                rd_req;
  logic                cpu_wr;
  logic                drive;
  logic                prog_fire;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  // WE wins over OE: a strobe with both high is a write.
  assign rd_req = CS & OE & ~WE;
  assign cpu_wr = CS & WE;

  // The drive enable is gated combinationally by the live bus controls so Data floats in the
  // same cycle the CPU lets go of OE/CS or turns the bus around with WE.
  assign drive    = (state_q == StRdDrive) & rd_req;
  assign Data     = drive ? rdata_q : {DATA_W{1'bz}};
  assign rd_valid = drive;

  assign busy       = (state_q == StRdWait);
  assign prog_ready = (state_q == StProg) & ~prog_done_q;
  assign prog_addr  = prog_addr_q;
  assign prog_done  = prog_done_q;
  assign prog_fire  = prog_ready & prog_valid;

  // Single RAM write port shared by the CPU bus and the programmer.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = Address;
    mem_wdata = Data;
    if (state_q == StProg) begin
      mem_we    = prog_fire;
      mem_waddr = prog_addr_q;
      mem_wdata = prog_data;
    end else if (!prog_en && cpu_wr && (state_q == StIdle || state_q == StRdDrive)) begin
      mem_we = 1'b1;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge master_reset_n) begin
    if (!master_reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_addr_q   <= '0;
      rdata_q     <= '0;
      prog_addr_q <= '0;
      prog_done_q <= 1'b0;
    end else if (state_q != StProg && prog_en) begin
      // Programming takes over the RAM from any CPU-side state.
      state_q     <= StProg;
      prog_addr_q <= '0;
      prog_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cpu_wr) begin
            state_q <= StIdle;
          end else if (rd_req) begin
            rd_addr_q <= Address;
            cnt_q     <= LatInit;
            if (READ_LAT <= 1) begin
              state_q <= StRdDrive;
              rdata_q <= mem[Address];
            end else begin
              state_q <= StRdWait;
            end
          end
        end

        StRdWait: begin
          if (!(CS && OE)) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q <= 2'd1) begin
            // Counter reaches zero on this edge: fetch and start driving.
            state_q <= StRdDrive;
            cnt_q   <= '0;
            rdata_q <= mem[rd_addr_q];
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end

        StRdDrive: begin
          // rdata is not refreshed on Address changes; a new read needs a fresh OE strobe.
          if (!(CS && OE) || WE) begin
            state_q <= StIdle;
          end
        end

        StProg: begin
          if (!prog_en) begin
            state_q     <= StIdle;
            prog_done_q <= 1'b0;
          end else if (prog_fire) begin
            prog_addr_q <= prog_addr_q + ADDR_W'(1);
            if (prog_addr_q == AddrLast) begin
              prog_done_q <= 1'b1;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
